mbc3_rtc: RTL

Parametrised clocked cartridge memory bank controller, the successor to the asynchronous MBC1 mapper.
- Widens the ROM/RAM bank registers via parameters.
- Adds a battery-style real-time clock with five counter registers, halt, day-overflow carry and a latch sequence.
- Sits between the DMG cartridge bus (a[15:13], d, nrd, nwr, ncs) and the ROM/SRAM models in the cartridge testbench.
- All bus inputs are sampled on clk.

---
 rtl/mbc_pkg.sv | 43 ++++
 rtl/mbc_rtc_counter.sv | 66 ++++++
 rtl/mbc3_rtc.sv | 96 +++++++++
 3 files changed

// File: rtl/mbc_pkg.sv
// Shared constants, RTC register bundle and read-mux helper for the MBC3 mapper.
package mbc_pkg;

   localparam logic [2:0] REG_ENA   = 3'b000;
   localparam logic [2:0] REG_ROM   = 3'b001;
   localparam logic [2:0] REG_SEL   = 3'b010;
   localparam logic [2:0] REG_LATCH = 3'b011;
   localparam logic [2:0] REG_RAM   = 3'b101;

   localparam logic [3:0] RTC_S  = 4'd8;
   localparam logic [3:0] RTC_M  = 4'd9;
   localparam logic [3:0] RTC_H  = 4'd10;
   localparam logic [3:0] RTC_DL = 4'd11;
   localparam logic [3:0] RTC_DH = 4'd12;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   // DH layout: bit7 day carry, bit6 halt, bit0 day8; the rest always read 0
   localparam logic [7:0] DH_MASK = 8'hC1;

   typedef struct packed {
      logic [5:0] s;
      logic [5:0] m;
      logic [4:0] h;
      logic [7:0] dl;
      logic [7:0] dh;
   } rtc_regs_t;

   function automatic logic [7:0] rtc_field(input rtc_regs_t r, input logic [2:0] idx);
      logic [7:0] v;
      case (idx)
         3'd0:    v = {2'b00, r.s};
         3'd1:    v = {2'b00, r.m};
         3'd2:    v = {3'b000, r.h};
         3'd3:    v = r.dl;
         3'd4:    v = r.dh;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/mbc_rtc_counter.sv
// Live and latched RTC registers with the seconds-to-days carry chain,
// a single bus write port and a latch strobe.
module mbc_rtc_counter
   import mbc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       wr_en,
   input  logic [2:0] wr_idx,
   input  logic [7:0] wr_data,
   input  logic       latch,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_data
);

   rtc_regs_t live, latched, nxt;
   logic       tick_en, s_carry, m_carry, h_carry, day_inc;
   logic       wr_s, wr_m, wr_h, wr_dl, wr_dh;
   logic [8:0] day_next;

   // A bus write replaces its register outright and suppresses any carry out of it
   always_comb begin
      nxt      = live;
      wr_s     = wr_en && (wr_idx == 3'd0);
      wr_m     = wr_en && (wr_idx == 3'd1);
      wr_h     = wr_en && (wr_idx == 3'd2);
      wr_dl    = wr_en && (wr_idx == 3'd3);
      wr_dh    = wr_en && (wr_idx == 3'd4);
      tick_en  = tick && !live.dh[6];
      s_carry  = tick_en && (live.s == SEC_MAX) && !wr_s;
      m_carry  = s_carry && (live.m == SEC_MAX) && !wr_m;
      h_carry  = m_carry && (live.h == HOUR_MAX) && !wr_h;
      day_inc  = h_carry && !wr_dl;
      day_next = {live.dh[0], live.dl} + 9'd1;

      if (tick_en) nxt.s = (live.s == SEC_MAX) ? 6'd0 : live.s + 6'd1;
      if (s_carry) nxt.m = (live.m == SEC_MAX) ? 6'd0 : live.m + 6'd1;
      if (m_carry) nxt.h = (live.h == HOUR_MAX) ? 5'd0 : live.h + 5'd1;
      if (day_inc) begin
         nxt.dl    = day_next[7:0];
         nxt.dh[0] = day_next[8];
         if (day_next == 9'd0) nxt.dh[7] = 1'b1;
      end

      if (wr_s)  nxt.s  = wr_data[5:0];
      if (wr_m)  nxt.m  = wr_data[5:0];
      if (wr_h)  nxt.h  = wr_data[4:0];
      if (wr_dl) nxt.dl = wr_data;
      if (wr_dh) nxt.dh = wr_data & DH_MASK;
   end

   // Latch copies the current live values, so a same-cycle tick is not seen
   always_ff @(posedge clk) begin
      if (rst) begin
         live    <= '0;
         latched <= '0;
      end else begin
         live <= nxt;
         if (latch) latched <= live;
      end
   end

   assign rd_data = rtc_field(latched, rd_idx);

endmodule

// File: rtl/mbc3_rtc.sv
// MBC3 cartridge mapper: ROM/RAM banking, RAM enable, RTC register select and
// latch sequencing on a clocked DMG cartridge bus.
module mbc3_rtc
   import mbc_pkg::*;
#(
   parameter int ROM_BANK_W = 7,
   parameter int RAM_BANK_W = 2,
   parameter int HAS_RTC    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            a,
   input  logic [7:0]            d,
   input  logic                  nrd,
   input  logic                  nwr,
   input  logic                  ncs,
   input  logic                  rtc_tick,
   output logic [ROM_BANK_W-1:0] ra,
   output logic [RAM_BANK_W-1:0] aa,
   output logic                  ncs_rom,
   output logic                  ncs_ram,
   output logic                  cs_ram,
   output logic [7:0]            rtc_dout,
   output logic                  rtc_oe
);

   localparam logic [4:0] RAM_SEL_LIMIT = 5'(1 << RAM_BANK_W);

   logic                  ena, latch_arm, nwr_q;
   logic [ROM_BANK_W-1:0] rom_bank;
   logic [3:0]            sel;
   logic                  commit, ram_hit, sel_ram, sel_rtc;
   logic                  rtc_wr, rtc_latch;
   logic [7:0]            rtc_rd;

   assign commit    = nwr_q && !nwr && !rst;
   assign sel_ram   = ({1'b0, sel} < RAM_SEL_LIMIT);
   assign sel_rtc   = (sel >= RTC_S) && (sel <= RTC_DH);
   assign rtc_wr    = commit && (a == REG_RAM) && !ncs && ena && sel_rtc;
   assign rtc_latch = commit && (a == REG_LATCH) && latch_arm && (d == 8'h01);

   // Each write commits once, on the falling edge of nwr as seen by clk
   always_ff @(posedge clk) begin
      if (rst) begin
         ena       <= 1'b0;
         rom_bank  <= '0;
         sel       <= 4'd0;
         latch_arm <= 1'b0;
         nwr_q     <= 1'b1;
      end else begin
         nwr_q <= nwr;
         if (commit) begin
            case (a)
               REG_ENA:   ena       <= (d[3:0] == 4'hA);
               REG_ROM:   rom_bank  <= d[ROM_BANK_W-1:0];
               REG_SEL:   sel       <= d[3:0];
               REG_LATCH: latch_arm <= (d == 8'h00);
               default:   ;
            endcase
         end
      end
   end

   generate
      if (HAS_RTC != 0) begin : g_rtc
         mbc_rtc_counter u_rtc (
            .clk     (clk),
            .rst     (rst),
            .tick    (rtc_tick),
            .wr_en   (rtc_wr),
            .wr_idx  (sel[2:0]),
            .wr_data (d),
            .latch   (rtc_latch),
            .rd_idx  (sel[2:0]),
            .rd_data (rtc_rd)
         );
      end else begin : g_no_rtc
         assign rtc_rd = 8'h00;
      end
   endgenerate

   assign ram_hit  = ena && !ncs && !a[1];
   assign ncs_rom  = !(!a[2] && !nrd) && !rst;
   assign ncs_ram  = !(ram_hit && sel_ram);
   assign cs_ram   = !ncs_ram;
   assign rtc_oe   = (HAS_RTC != 0) && ram_hit && !nrd && sel_rtc;
   assign rtc_dout = rtc_oe ? rtc_rd : 8'h00;
   assign aa       = sel_ram ? sel[RAM_BANK_W-1:0] : '0;

   // Bank 0 in the switchable window aliases to bank 1
   always_comb begin
      ra = '0;
      if (!rst && a[1]) ra = (rom_bank == '0) ? ROM_BANK_W'(1) : rom_bank;
   end

endmodule
